// File: rtl/pc_sequencer.sv
// Program-counter unit for the single-cycle MIPS core: next-PC selection,
// misaligned jump-register detection and a count of cycles in which the PC advanced.
module pc_sequencer #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(32'h0000_0000),
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h0000_0080),
    parameter int               CNT_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 branch_taken,
    input  logic [15:0]          branch_offset,
    input  logic                 jump,
    input  logic [25:0]          jump_index,
    input  logic                 jump_reg,
    input  logic [WIDTH-1:0]     jump_target,
    input  logic                 exception,
    output logic [WIDTH-1:0]     pc,
    output logic [WIDTH-1:0]     pc_plus4,
    output logic                 misaligned,
    output logic [CNT_WIDTH-1:0] adv_count
);

    logic [WIDTH-1:0]     pc_r;
    logic                 misaligned_r;
    logic [CNT_WIDTH-1:0] adv_count_r;

    logic [WIDTH-1:0]     pc_plus4_s;
    logic [WIDTH-1:0]     branch_disp_s;
    logic [WIDTH-1:0]     branch_pc_s;
    logic [WIDTH-1:0]     jump_pc_s;
    logic [WIDTH-1:0]     next_pc_s;
    logic                 next_misaligned_s;
    logic                 advance_s;

    assign pc_plus4_s    = pc_r + {{(WIDTH-3){1'b0}}, 3'b100};
    // Word offset sign-extended and scaled to bytes; the sum wraps silently.
    assign branch_disp_s = {{(WIDTH-18){branch_offset[15]}}, branch_offset, 2'b00};
    assign branch_pc_s   = pc_plus4_s + branch_disp_s;

    // A 28-bit PC has no region bits to carry over from pc_plus4.
    generate
        if (WIDTH > 28) begin : g_jump_region
            assign jump_pc_s = {pc_plus4_s[WIDTH-1:28], jump_index, 2'b00};
        end else begin : g_jump_flat
            assign jump_pc_s = {jump_index, 2'b00};
        end
    endgenerate

    // Next-PC selection in priority order: exception, stall, jr, j, branch, sequential.
    always_comb begin
        next_pc_s         = pc_plus4_s;
        next_misaligned_s = 1'b0;
        advance_s         = 1'b1;
        if (exception) begin
            next_pc_s = EXC_VECTOR;
        end else if (stall) begin
            next_pc_s = pc_r;
            advance_s = 1'b0;
        end else if (jump_reg) begin
            if (jump_target[1:0] == 2'b00) begin
                next_pc_s = jump_target;
            end else begin
                next_pc_s         = EXC_VECTOR;
                next_misaligned_s = 1'b1;
            end
        end else if (jump) begin
            next_pc_s = jump_pc_s;
        end else if (branch_taken) begin
            next_pc_s = branch_pc_s;
        end else begin
            next_pc_s = pc_plus4_s;
        end
    end

    // State register with synchronous reset overriding every request.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r         <= RESET_VECTOR;
            misaligned_r <= 1'b0;
            adv_count_r  <= {CNT_WIDTH{1'b0}};
        end else begin
            pc_r         <= next_pc_s;
            misaligned_r <= next_misaligned_s;
            if (advance_s) begin
                adv_count_r <= adv_count_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                adv_count_r <= adv_count_r;
            end
        end
    end

    assign pc         = pc_r;
    assign pc_plus4   = pc_plus4_s;
    assign misaligned = misaligned_r;
    assign adv_count  = adv_count_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer with hand-computed expectations.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_offset;
    logic        jump;
    logic [25:0] jump_index;
    logic        jump_reg;
    logic [31:0] jump_target;
    logic        exception;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        misaligned;
    logic [31:0] adv_count;

    int n_checks = 0;
    int n_errors = 0;

    pc_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_index    (jump_index),
        .jump_reg      (jump_reg),
        .jump_target   (jump_target),
        .exception     (exception),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .misaligned    (misaligned),
        .adv_count     (adv_count)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic idle_inputs();
        stall = 1'b0; branch_taken = 1'b0; branch_offset = 16'h0000;
        jump = 1'b0; jump_index = 26'h0; jump_reg = 1'b0;
        jump_target = 32'h0; exception = 1'b0;
    endtask

    // Advance one edge and sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_state(input string tag, input logic [31:0] e_pc,
                                input logic e_mis, input logic [31:0] e_cnt);
        check_value({tag, ".pc"}, pc, e_pc);
        check_value({tag, ".pc_plus4"}, pc_plus4, e_pc + 32'd4);
        check_value({tag, ".misaligned"}, {31'd0, misaligned}, {31'd0, e_mis});
        check_value({tag, ".adv_count"}, adv_count, e_cnt);
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        step();
        expect_state("reset", 32'h0, 1'b0, 32'd0);
        rst = 1'b0;

        step(); expect_state("seq1", 32'h4, 1'b0, 32'd1);
        step(); expect_state("seq2", 32'h8, 1'b0, 32'd2);
        step(); expect_state("seq3", 32'hC, 1'b0, 32'd3);

        jump_reg = 1'b1; jump_target = 32'h40;
        step(); expect_state("jr_40", 32'h40, 1'b0, 32'd4);
        idle_inputs();

        branch_taken = 1'b1; branch_offset = 16'hFFFE;
        step(); expect_state("br_back", 32'h3C, 1'b0, 32'd5);
        branch_offset = 16'h0003;
        step(); expect_state("br_fwd", 32'h4C, 1'b0, 32'd6);
        idle_inputs();

        jump_reg = 1'b1; jump_target = 32'h1000_0000;
        step(); expect_state("jr_region", 32'h1000_0000, 1'b0, 32'd7);
        idle_inputs();
        jump = 1'b1; jump_index = 26'h0000100;
        branch_taken = 1'b1; branch_offset = 16'h0010;
        step(); expect_state("jump_over_br", 32'h1000_0400, 1'b0, 32'd8);
        idle_inputs();

        jump_reg = 1'b1; jump_target = 32'h2002;
        step(); expect_state("jr_misaligned", 32'h80, 1'b1, 32'd9);
        jump_target = 32'h2000;
        step(); expect_state("jr_aligned", 32'h2000, 1'b0, 32'd10);

        jump_target = 32'h20;
        step(); expect_state("jr_20", 32'h20, 1'b0, 32'd11);
        idle_inputs();
        stall = 1'b1; jump = 1'b1; jump_index = 26'h0000ABC;
        step(); expect_state("stall1", 32'h20, 1'b0, 32'd11);
        step(); expect_state("stall2", 32'h20, 1'b0, 32'd11);
        exception = 1'b1;
        step(); expect_state("stall_exc", 32'h80, 1'b0, 32'd12);
        idle_inputs();

        jump_reg = 1'b1; jump_target = 32'h0000_0003;
        step(); expect_state("jr_mis2", 32'h80, 1'b1, 32'd13);
        idle_inputs();
        stall = 1'b1;
        step(); expect_state("stall_clr_mis", 32'h80, 1'b0, 32'd13);
        idle_inputs();

        jump_reg = 1'b1; jump_target = 32'hFFFF_FFFC;
        step();
        check_value("top.pc", pc, 32'hFFFF_FFFC);
        check_value("top.pc_plus4_wrap", pc_plus4, 32'h0);
        idle_inputs();
        step(); expect_state("seq_wrap", 32'h0, 1'b0, 32'd15);

        step(); expect_state("seq_after_wrap", 32'h4, 1'b0, 32'd16);
        branch_taken = 1'b1; branch_offset = 16'h0100; rst = 1'b1;
        step(); expect_state("rst_mid", 32'h0, 1'b0, 32'd0);
        rst = 1'b0; branch_offset = 16'h0001;
        step(); expect_state("br_after_rst", 32'h8, 1'b0, 32'd1);
        idle_inputs();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
